// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: core (c_*) and debug (d_*) requester channels plus the memory macro side (m_*).
// slave is the arbiter's view; master is the view of the environment driving requesters and the memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            c_req;
    logic            c_we;
    logic [AW-1:0]   c_addr;
    logic [DW-1:0]   c_wdata;
    logic [DW/8-1:0] c_wstrb;
    logic            c_gnt;
    logic            c_rvalid;
    logic [DW-1:0]   c_rdata;

    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_wstrb;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            m_rden;
    logic            m_wren;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic [DW-1:0]   m_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_wstrb,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata,
        output m_rden, m_wren, m_addr, m_wdata, m_wstrb,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_wstrb,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_rden, m_wren, m_addr, m_wdata, m_wstrb,
        output m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-ported unified memory with zero-latency issue and fixed read latency tracking.
// Define MEM_ARB_RR_EN for round-robin selection; default is fixed core priority.
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);
    localparam int CW = $clog2(RD_LAT + 1);
    localparam int SW = DW / 8;

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("mem_port_arbiter: RD_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic {IDLE, RD_WAIT} state_t;
    typedef enum logic {PORT_C, PORT_D} port_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    port_t          owner_reg, owner_next;
    port_t          last_reg, last_next;

    logic           rvalid_fire;
    logic           window;
    logic           issue;
    logic           pick_d;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic [SW-1:0]  sel_wstrb;

    // The data-return cycle of a read doubles as an arbitration window.
    always_comb begin
        rvalid_fire = !rst && (state_reg == RD_WAIT) && (cnt_reg == CW'(1));
        window      = !rst && ((state_reg == IDLE) || rvalid_fire);
        issue       = window && (bus.c_req || bus.d_req);
`ifdef MEM_ARB_RR_EN
        pick_d      = bus.d_req && (!bus.c_req || (last_reg == PORT_C));
`else
        pick_d      = bus.d_req && !bus.c_req;
`endif
        sel_we      = pick_d ? bus.d_we    : bus.c_we;
        sel_addr    = pick_d ? bus.d_addr  : bus.c_addr;
        sel_wdata   = pick_d ? bus.d_wdata : bus.c_wdata;
        sel_wstrb   = pick_d ? bus.d_wstrb : bus.c_wstrb;
    end

    assign bus.c_gnt    = issue && !pick_d;
    assign bus.d_gnt    = issue && pick_d;
    assign bus.c_rvalid = rvalid_fire && (owner_reg == PORT_C);
    assign bus.d_rvalid = rvalid_fire && (owner_reg == PORT_D);
    assign bus.c_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

    // Memory fields are zeroed whenever nothing issues so the macro never sees stale requester fields.
    assign bus.m_rden   = issue && !sel_we;
    assign bus.m_wren   = issue && sel_we;
    assign bus.m_addr   = issue ? sel_addr  : '0;
    assign bus.m_wdata  = issue ? sel_wdata : '0;
    assign bus.m_wstrb  = issue ? sel_wstrb : '0;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        if (issue) begin
            last_next = pick_d ? PORT_D : PORT_C;
        end
        if (issue && !sel_we) begin
            state_next = RD_WAIT;
            cnt_next   = CW'(RD_LAT);
            owner_next = pick_d ? PORT_D : PORT_C;
        end else if (state_reg == RD_WAIT) begin
            if (cnt_reg == CW'(1)) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                cnt_next   = cnt_reg - CW'(1);
            end
        end
    end

    // Reset drops any outstanding read so no stale rvalid follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            owner_reg <= PORT_C;
            last_reg  <= PORT_C;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at RD_LAT 1, 2 and 3, each with a byte-enabled memory model.
// Round-robin expectations apply when MEM_ARB_RR_EN is defined for the build.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    logic [2:0]  c_req, c_we, d_req, d_we;
    logic [31:0] c_addr [3];
    logic [31:0] c_wdata[3];
    logic [3:0]  c_wstrb[3];
    logic [31:0] d_addr [3];
    logic [31:0] d_wdata[3];
    logic [3:0]  d_wstrb[3];

    logic [2:0]  c_gnt, c_rvalid, d_gnt, d_rvalid, m_rden, m_wren;
    logic [31:0] c_rdata[3];
    logic [31:0] d_rdata[3];
    logic [31:0] m_addr [3];
    logic [3:0]  m_wstrb[3];

    int checks = 0;
    int errors = 0;

`ifdef MEM_ARB_RR_EN
    localparam logic [2:0] D_WINS = 3'b010;
`else
    localparam logic [2:0] D_WINS = 3'b000;
`endif

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a < 32'h20) ? 32'h0 : (32'h5A00_0000 | a);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_lat
        mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

        mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(gi + 1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.c_req   = c_req[gi];
        assign bus.c_we    = c_we[gi];
        assign bus.c_addr  = c_addr[gi];
        assign bus.c_wdata = c_wdata[gi];
        assign bus.c_wstrb = c_wstrb[gi];
        assign bus.d_req   = d_req[gi];
        assign bus.d_we    = d_we[gi];
        assign bus.d_addr  = d_addr[gi];
        assign bus.d_wdata = d_wdata[gi];
        assign bus.d_wstrb = d_wstrb[gi];

        assign c_gnt[gi]    = bus.c_gnt;
        assign c_rvalid[gi] = bus.c_rvalid;
        assign c_rdata[gi]  = bus.c_rdata;
        assign d_gnt[gi]    = bus.d_gnt;
        assign d_rvalid[gi] = bus.d_rvalid;
        assign d_rdata[gi]  = bus.d_rdata;
        assign m_rden[gi]   = bus.m_rden;
        assign m_wren[gi]   = bus.m_wren;
        assign m_addr[gi]   = bus.m_addr;
        assign m_wstrb[gi]  = bus.m_wstrb;

        logic [31:0] mem  [256];
        logic [31:0] pipe [gi + 1];
        bit          inited = 1'b0;

        always @(posedge clk) begin
            if (!inited) begin
                for (int i = 0; i < 256; i++) mem[i] <= pat(32'(i * 4));
                inited <= 1'b1;
            end else if (bus.m_wren) begin
                for (int b = 0; b < 4; b++)
                    if (bus.m_wstrb[b]) mem[bus.m_addr[9:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
            end
            pipe[0] <= bus.m_rden ? mem[bus.m_addr[9:2]] : 32'hDEAD_BEEF;
            for (int s = 1; s <= gi; s++) pipe[s] <= pipe[s-1];
        end
        assign bus.m_rdata = pipe[gi];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        c_req = '0; c_we = '0; d_req = '0; d_we = '0;
        for (int i = 0; i < 3; i++) begin
            c_addr[i] = '0; c_wdata[i] = '0; c_wstrb[i] = '0;
            d_addr[i] = '0; d_wdata[i] = '0; d_wstrb[i] = '0;
        end

        // Reset: a pending request must stay invisible while rst is high
        c_req[1] = 1'b1; c_addr[1] = 32'h100;
        cyc(); cyc(); smp();
        chk("rst_c_gnt",    32'(c_gnt[1]),    0);
        chk("rst_m_rden",   32'(m_rden[1]),   0);
        chk("rst_m_addr",   m_addr[1],        0);
        chk("rst_c_rvalid", 32'(c_rvalid[1]), 0);
        cyc(); rst = 1'b0;

        // Core read, RD_LAT=2
        smp();
        $display("txn core_read lat2 addr=100 gnt=%0b rden=%0b", c_gnt[1], m_rden[1]);
        chk("t1_c_gnt",  32'(c_gnt[1]),  1);
        chk("t1_m_rden", 32'(m_rden[1]), 1);
        chk("t1_m_addr", m_addr[1],      32'h100);
        chk("t1_d_gnt",  32'(d_gnt[1]),  0);
        cyc(); c_req[1] = 1'b0;
        smp();
        chk("t1_c_rvalid_early", 32'(c_rvalid[1]), 0);
        cyc(); smp();
        chk("t1_c_rvalid", 32'(c_rvalid[1]), 1);
        chk("t1_c_rdata",  c_rdata[1],       pat(32'h100));
        chk("t1_d_rvalid", 32'(d_rvalid[1]), 0);
        cyc(); smp();
        chk("t1_c_rvalid_after", 32'(c_rvalid[1]), 0);

        // Back-to-back writes then readback, RD_LAT=1
        cyc();
        c_req[0] = 1'b1; c_we[0] = 1'b1; c_addr[0] = 32'h10; c_wdata[0] = 32'hA5A5_A5A5; c_wstrb[0] = 4'hF;
        smp();
        $display("txn core_write lat1 addr=10 gnt=%0b wren=%0b", c_gnt[0], m_wren[0]);
        chk("t2_w0_c_gnt",  32'(c_gnt[0]),  1);
        chk("t2_w0_m_wren", 32'(m_wren[0]), 1);
        chk("t2_w0_m_rden", 32'(m_rden[0]), 0);
        chk("t2_w0_m_addr", m_addr[0],      32'h10);
        cyc();
        c_addr[0] = 32'h14; c_wdata[0] = 32'h1; c_wstrb[0] = 4'h1;
        smp();
        $display("txn core_write lat1 addr=14 gnt=%0b wren=%0b", c_gnt[0], m_wren[0]);
        chk("t2_w1_c_gnt",   32'(c_gnt[0]),  1);
        chk("t2_w1_m_wren",  32'(m_wren[0]), 1);
        chk("t2_w1_m_addr",  m_addr[0],      32'h14);
        chk("t2_w1_m_wstrb", 32'(m_wstrb[0]), 32'h1);
        cyc();
        c_we[0] = 1'b0; c_addr[0] = 32'h10;
        smp();
        chk("t2_r0_c_gnt",  32'(c_gnt[0]),  1);
        chk("t2_r0_m_rden", 32'(m_rden[0]), 1);
        cyc();
        c_addr[0] = 32'h14;
        smp();
        $display("txn core_readback lat1 addr=10 rvalid=%0b data=%h", c_rvalid[0], c_rdata[0]);
        chk("t2_r0_c_rvalid", 32'(c_rvalid[0]), 1);
        chk("t2_r0_c_rdata",  c_rdata[0],       32'hA5A5_A5A5);
        chk("t2_r1_c_gnt",    32'(c_gnt[0]),    1);
        cyc(); c_req[0] = 1'b0;
        smp();
        $display("txn core_readback lat1 addr=14 rvalid=%0b data=%h", c_rvalid[0], c_rdata[0]);
        chk("t2_r1_c_rvalid", 32'(c_rvalid[0]), 1);
        chk("t2_r1_c_rdata",  c_rdata[0],       32'h0000_0001);

        // Overlap at data return: debug write granted in the core's rvalid cycle, RD_LAT=1
        cyc();
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h20;
        smp();
        chk("t5_c_gnt", 32'(c_gnt[0]), 1);
        cyc();
        c_req[0] = 1'b0;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h24; d_wdata[0] = 32'h1234_5678; d_wstrb[0] = 4'hF;
        smp();
        $display("txn overlap lat1 c_rvalid=%0b d_gnt=%0b wren=%0b addr=%h", c_rvalid[0], d_gnt[0], m_wren[0], m_addr[0]);
        chk("t5_c_rvalid", 32'(c_rvalid[0]), 1);
        chk("t5_c_rdata",  c_rdata[0],       pat(32'h20));
        chk("t5_d_gnt",    32'(d_gnt[0]),    1);
        chk("t5_c_gnt",    32'(c_gnt[0]),    0);
        chk("t5_m_wren",   32'(m_wren[0]),   1);
        chk("t5_m_addr",   m_addr[0],        32'h24);
        cyc();
        d_we[0] = 1'b0;
        smp();
        chk("t5_rd_d_gnt",  32'(d_gnt[0]),  1);
        chk("t5_rd_m_rden", 32'(m_rden[0]), 1);
        cyc(); d_req[0] = 1'b0;
        smp();
        $display("txn debug_readback lat1 addr=24 rvalid=%0b data=%h", d_rvalid[0], d_rdata[0]);
        chk("t5_d_rvalid", 32'(d_rvalid[0]), 1);
        chk("t5_d_rdata",  d_rdata[0],       32'h1234_5678);
        chk("t5_c_rvalid_quiet", 32'(c_rvalid[0]), 0);

        // Simultaneous reads held for three windows, RD_LAT=1 (last owner is debug here)
        cyc();
        c_req[0] = 1'b1; c_addr[0] = 32'h100;
        d_req[0] = 1'b1; d_addr[0] = 32'h104;
        for (int k = 0; k < 4; k++) begin
            smp();
            $display("txn contend lat1 win=%0d c_gnt=%0b d_gnt=%0b c_rvalid=%0b d_rvalid=%0b", k, c_gnt[0], d_gnt[0], c_rvalid[0], d_rvalid[0]);
            if (k < 3) begin
                chk($sformatf("t3_c_gnt_%0d", k), 32'(c_gnt[0]), 32'(!D_WINS[k]));
                chk($sformatf("t3_d_gnt_%0d", k), 32'(d_gnt[0]), 32'(D_WINS[k]));
            end
            if (k > 0) begin
                chk($sformatf("t3_c_rvalid_%0d", k), 32'(c_rvalid[0]), 32'(!D_WINS[k-1]));
                chk($sformatf("t3_d_rvalid_%0d", k), 32'(d_rvalid[0]), 32'(D_WINS[k-1]));
                if (D_WINS[k-1]) chk($sformatf("t3_d_rdata_%0d", k), d_rdata[0], pat(32'h104));
                else             chk($sformatf("t3_c_rdata_%0d", k), c_rdata[0], pat(32'h100));
            end
            cyc();
            if (k == 2) begin
                c_req[0] = 1'b0;
                d_req[0] = 1'b0;
            end
        end

        // Reset one cycle after a debug read issues, RD_LAT=3
        d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 32'h100;
        smp();
        chk("t4_d_gnt",  32'(d_gnt[2]),  1);
        chk("t4_m_rden", 32'(m_rden[2]), 1);
        cyc();
        d_req[2] = 1'b0; rst = 1'b1;
        smp();
        chk("t4_rst_d_rvalid", 32'(d_rvalid[2]), 0);
        cyc();
        rst = 1'b0; c_req[2] = 1'b1; c_addr[2] = 32'h104;
        smp();
        $display("txn post_reset lat3 c_gnt=%0b addr=%h d_rvalid=%0b", c_gnt[2], m_addr[2], d_rvalid[2]);
        chk("t4_c_gnt",    32'(c_gnt[2]),    1);
        chk("t4_m_addr",   m_addr[2],        32'h104);
        chk("t4_d_rvalid", 32'(d_rvalid[2]), 0);
        cyc(); c_req[2] = 1'b0;
        for (int k = 3; k < 6; k++) begin
            smp();
            $display("txn post_reset lat3 cycle=%0d c_rvalid=%0b d_rvalid=%0b", k, c_rvalid[2], d_rvalid[2]);
            chk($sformatf("t4_d_rvalid_%0d", k), 32'(d_rvalid[2]), 0);
            chk($sformatf("t4_c_rvalid_%0d", k), 32'(c_rvalid[2]), 32'(k == 5));
            if (k == 5) chk("t4_c_rdata", c_rdata[2], pat(32'h104));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters.
  - Core port: the multicycle control unit's mem_rden/mem_wren path.
  - Debug/DMA port: program loader and debug access.
- Issues at most one memory operation per cycle and tracks the fixed read latency.
- Routes read data and a valid strobe back to the requester that issued the read.
- Sits between the core datapath and the memory macro; the core's done input is derived from c_gnt/c_rvalid.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)
RD_LAT, 1, memory read latency in cycles, legal range 1..4

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
c_req  in  1  core request, level, held until c_gnt
c_we  in  1  core write (1) / read (0)
c_addr  in  AW  core address
c_wdata  in  DW  core write data
c_wstrb  in  DW/8  core byte enables (writes only)
c_gnt  out  1  core request issued this cycle (pulse)
c_rvalid  out  1  core read data valid (pulse)
c_rdata  out  DW  core read data
d_req, d_we, d_addr, d_wdata, d_wstrb  in  1/1/AW/DW/DW/8  debug port, same semantics as core
d_gnt  out  1  debug issued (pulse)
d_rvalid  out  1  debug read data valid
d_rdata  out  DW  debug read data
m_rden  out  1  memory read enable
m_wren  out  1  memory write enable
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_wstrb  out  DW/8  memory byte enables
m_rdata  in  DW  memory read data, valid RD_LAT cycles after m_rden

Behaviour:
- States: IDLE and RD_WAIT; down-counter cnt (width clog2(RD_LAT+1)); owner register (C/D); last register (C/D).
- Reset values:
  - Registers: state=IDLE, cnt=0, owner=C, last=C.
  - While rst is high, all combinational outputs are 0: gnt, rvalid, m_rden, m_wren.
  - m_addr, m_wdata and m_wstrb are 0 during rst.
- Arbitration window: the arbiter can issue when state==IDLE, or when state==RD_WAIT and cnt==1 (the data-return cycle).
- Issue cycle, when the window is open and any req is high:
  - Select a winner combinationally.
  - Assert the winner's gnt and drive m_* from the winner's fields in the same cycle (zero-latency issue).
  - m_rden = !we, m_wren = we.
  - last <= winner.
- Write issue: completes in the issue cycle; next state IDLE; back-to-back writes one per cycle.
- Read issue: owner <= winner, cnt <= RD_LAT, next state RD_WAIT.
- RD_WAIT: cnt decrements each cycle.
  - At cnt==1, assert owner's rvalid, with rdata=m_rdata passthrough.
  - Same cycle: arbitrate again. Next state is RD_WAIT if a new read is issued, otherwise IDLE.
- Read throughput: one read per RD_LAT cycles. For RD_LAT=1, reads issue every cycle.
- No window open: both gnt are 0 and m_rden/m_wren are 0; requests remain pending.
- Priority (default): fixed, core wins over debug on simultaneous req.
- rdata outputs: c_rdata and d_rdata both carry m_rdata at all times; only the rvalid strobes are steered.
- Requester rule: req, we, addr, wdata and wstrb stay stable from req rise until gnt. The arbiter does not latch fields before gnt.
- Request dropped before gnt: no operation is issued and no error is raised.
- Reset mid-read: the pending read is discarded and no rvalid is produced after rst deasserts.
- A requester may re-request in its own rvalid cycle and can be granted in that cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin.
  - On simultaneous req, grant the requester not equal to last.
  - A single requester is always granted.
  - Guarantees debug service within 2 windows under continuous core traffic.
- Undefined: fixed core priority as above. last is still maintained but unused for selection.

Test Plan:
- Core read, RD_LAT=2: c_req=1, c_we=0, c_addr=0x100.
  - Required: c_gnt and m_rden high in cycle 0 with m_addr=0x100.
  - Required: c_rvalid in cycle 2 with c_rdata=mem[0x100]; d_rvalid stays 0.
- Back-to-back writes, RD_LAT=1: core writes 0xA5A5A5A5 to 0x10 with wstrb=0xF, then 0x1 with wstrb=0x1 to 0x14.
  - Required: two consecutive c_gnt and m_wren cycles.
  - Required: readback returns 0xA5A5A5A5 and 0x00000001.
- Simultaneous read requests, fixed priority, held 3 windows: c_req=d_req=1.
  - Required: c_gnt in all 3 windows and d_gnt never.
- Same stimulus with MEM_ARB_RR_EN defined.
  - Required: grant order C, D, C.
  - Required: each rvalid is steered to the matching owner with the correct address data.
- Reset mid-read, RD_LAT=3: rst asserted 1 cycle after a debug read is issued.
  - Required: d_rvalid never asserts.
  - Required: state is IDLE and a new core read is granted in the first cycle after rst deasserts.
- Overlap at data return, RD_LAT=1: core read 0x20 issued; debug write 0x24 requested in the core's rvalid cycle.
  - Required: c_rvalid and d_gnt in the same cycle, with m_wren=1 and m_addr=0x24.
